// File: rtl/vpp_scan_ctrl.sv
// vpp_scan_ctrl: multi-channel peak-to-peak scheduler.
// Time-shares one min/max tracker across CH_NUM analog channels. For each
// enabled channel it selects the analog mux, discards SETTLE samples, then
// tracks max/min over POINTS samples. The results go to a per-channel bank
// that the host reads through a registered port. A start/busy/done handshake
// and a sticky irq line report scan completion.
// Optional feature macro: VPP_SCAN_CONT_EN adds input 'cont'. When it is set,
// a finished scan restarts at once with the same latched mask.
module vpp_scan_ctrl #(
  parameter int DATA_W = 12,
  parameter int CH_NUM = 4,
  parameter int CH_W   = 2,
  parameter int POINTS = 200,
  parameter int SETTLE = 8
) (
  input  logic              clk_fs,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CH_NUM-1:0] ch_mask,
  input  logic [DATA_W-1:0] data_u,
`ifdef VPP_SCAN_CONT_EN
  input  logic              cont,
`endif
  input  logic              irq_clr,
  input  logic [CH_W-1:0]   rd_ch,
  output logic [CH_W-1:0]   ch_sel,
  output logic              busy,
  output logic              done,
  output logic              irq,
  output logic [DATA_W-1:0] rd_max,
  output logic [DATA_W-1:0] rd_min,
  output logic [DATA_W-1:0] rd_vpp
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_SETTLE,
    S_MEAS,
    S_STORE
  } state_t;

  // One counter serves both the settle phase and the measurement window.
  localparam int CNT_MAX = (POINTS > SETTLE) ? POINTS : SETTLE;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CH_W-1:0]  LAST_IDX    = CH_W'(CH_NUM - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] POINTS_LAST = CNT_W'(POINTS - 1);

  state_t              r_state;
  state_t              w_next;
  logic [CH_NUM-1:0]   r_mask;
  logic [CH_W-1:0]     r_idx;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_max;
  logic [DATA_W-1:0]   r_min;
  logic [CH_W-1:0]     r_ch_sel;
  logic                r_busy;
  logic                r_done;
  logic                r_irq;
  logic [DATA_W-1:0]   r_bank_max [CH_NUM];
  logic [DATA_W-1:0]   r_bank_min [CH_NUM];
  logic [DATA_W-1:0]   r_bank_vpp [CH_NUM];
  logic [DATA_W-1:0]   r_rd_max;
  logic [DATA_W-1:0]   r_rd_min;
  logic [DATA_W-1:0]   r_rd_vpp;

  // Control strobes produced by the next-state logic.
  logic w_accept;   // start accepted in IDLE
  logic w_sel;      // enabled channel found: drive mux, begin settling
  logic w_adv;      // move on to the next channel index
  logic w_cnt_clr;  // restart the phase counter
  logic w_store;    // write the tracked result into the bank
  logic w_finish;   // scan complete
  logic w_restart;  // scan complete and continuous mode keeps going
  logic w_cont;

`ifdef VPP_SCAN_CONT_EN
  assign w_cont = cont;
`else
  assign w_cont = 1'b0;
`endif

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values and no result depends on the order of always blocks.
  always_ff @(posedge clk_fs or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode and per-cycle control strobes.
  always_comb begin
    // NOTE: every signal gets a default first; a path that leaves one
    // unassigned would infer a latch.
    w_next    = r_state;
    w_accept  = 1'b0;
    w_sel     = 1'b0;
    w_adv     = 1'b0;
    w_cnt_clr = 1'b0;
    w_store   = 1'b0;
    w_finish  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = S_SCAN;
        end
      end
      S_SCAN: begin
        if (r_mask[r_idx]) begin
          w_sel     = 1'b1;
          w_cnt_clr = 1'b1;
          w_next    = S_SETTLE;
        end else if (r_idx == LAST_IDX) begin
          w_finish = 1'b1;
        end else begin
          w_adv = 1'b1;
        end
      end
      S_SETTLE: begin
        if (r_cnt == SETTLE_LAST) begin
          w_cnt_clr = 1'b1;
          w_next    = S_MEAS;
        end
      end
      S_MEAS: begin
        if (r_cnt == POINTS_LAST) begin
          w_cnt_clr = 1'b1;
          w_next    = S_STORE;
        end
      end
      S_STORE: begin
        w_store = 1'b1;
        if (r_idx == LAST_IDX) begin
          w_finish = 1'b1;
        end else begin
          w_adv  = 1'b1;
          w_next = S_SCAN;
        end
      end
      default: w_next = S_IDLE;
    endcase
    if (w_finish) w_next = w_cont ? S_SCAN : S_IDLE;
  end

  assign w_restart = w_finish & w_cont;

  // Scan sequencing: latched mask, channel index, phase counter, mux select.
  always_ff @(posedge clk_fs or negedge rst_n) begin
    if (!rst_n) begin
      r_mask   <= '0;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_ch_sel <= '0;
    end else begin
      if (w_accept) r_mask <= ch_mask;
      if (w_accept || w_restart) r_idx <= '0;
      else if (w_adv)            r_idx <= r_idx + 1'b1;
      if (w_cnt_clr)                                      r_cnt <= '0;
      else if (r_state == S_SETTLE || r_state == S_MEAS)  r_cnt <= r_cnt + 1'b1;
      if (w_sel) r_ch_sel <= r_idx;
    end
  end

  // Min/max tracker: the first window sample seeds both, later ones compare.
  always_ff @(posedge clk_fs or negedge rst_n) begin
    if (!rst_n) begin
      r_max <= '0;
      r_min <= '0;
    end else if (r_state == S_MEAS) begin
      if (r_cnt == '0) begin
        r_max <= data_u;
        r_min <= data_u;
      end else begin
        if (data_u > r_max) r_max <= data_u;
        if (data_u < r_min) r_min <= data_u;
      end
    end
  end

  // Handshake: busy across the scan, one-cycle done, sticky irq.
  // irq_clr outranks the set that comes with done.
  always_ff @(posedge clk_fs or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_irq  <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_accept)      r_busy <= 1'b1;
      else if (w_finish) r_busy <= w_cont;
      if (irq_clr || w_accept) r_irq <= 1'b0;
      else if (w_finish)       r_irq <= 1'b1;
    end
  end

  // Result bank; only STORE writes it, so masked-off channels keep old data.
  // NOTE: the bank is a small flop array that is reset on purpose, because the
  // host must read zeros after reset. Larger RAM-style storage would not be reset.
  always_ff @(posedge clk_fs or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH_NUM; i++) begin
        r_bank_max[i] <= '0;
        r_bank_min[i] <= '0;
        r_bank_vpp[i] <= '0;
      end
    end else if (w_store) begin
      r_bank_max[r_idx] <= r_max;
      r_bank_min[r_idx] <= r_min;
      r_bank_vpp[r_idx] <= r_max - r_min;
    end
  end

  // Registered read port. A same-cycle write is seen on the following read.
  always_ff @(posedge clk_fs or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_max <= '0;
      r_rd_min <= '0;
      r_rd_vpp <= '0;
    end else begin
      r_rd_max <= r_bank_max[rd_ch];
      r_rd_min <= r_bank_min[rd_ch];
      r_rd_vpp <= r_bank_vpp[rd_ch];
    end
  end

  assign ch_sel = r_ch_sel;
  assign busy   = r_busy;
  assign done   = r_done;
  assign irq    = r_irq;
  assign rd_max = r_rd_max;
  assign rd_min = r_rd_min;
  assign rd_vpp = r_rd_vpp;

endmodule

// File: tb/tb_vpp_scan_ctrl.sv
// Self-checking bench for vpp_scan_ctrl with a small configuration
// (CH_NUM=4, POINTS=4, SETTLE=2).
// A reference model works out each enabled channel's measurement window from
// the per-channel cycle cost. It then takes max/min of the samples driven in
// that window and keeps its own copy of the result bank.
module tb_vpp_scan_ctrl;
  localparam int DATA_W = 12;
  localparam int CH_NUM = 4;
  localparam int CH_W   = 2;
  localparam int POINTS = 4;
  localparam int SETTLE = 2;

  logic              clk_fs  = 1'b0;
  logic              rst_n   = 1'b0;
  logic              start   = 1'b0;
  logic [CH_NUM-1:0] ch_mask = '0;
  logic [DATA_W-1:0] data_u  = '0;
  logic              irq_clr = 1'b0;
  logic [CH_W-1:0]   rd_ch   = '0;
`ifdef VPP_SCAN_CONT_EN
  logic              cont    = 1'b0;
`endif
  logic [CH_W-1:0]   ch_sel;
  logic              busy, done, irq;
  logic [DATA_W-1:0] rd_max, rd_min, rd_vpp;

  vpp_scan_ctrl #(
    .DATA_W(DATA_W), .CH_NUM(CH_NUM), .CH_W(CH_W),
    .POINTS(POINTS), .SETTLE(SETTLE)
  ) dut (
    .clk_fs (clk_fs),
    .rst_n  (rst_n),
    .start  (start),
    .ch_mask(ch_mask),
    .data_u (data_u),
`ifdef VPP_SCAN_CONT_EN
    .cont   (cont),
`endif
    .irq_clr(irq_clr),
    .rd_ch  (rd_ch),
    .ch_sel (ch_sel),
    .busy   (busy),
    .done   (done),
    .irq    (irq),
    .rd_max (rd_max),
    .rd_min (rd_min),
    .rd_vpp (rd_vpp)
  );

  always #5 clk_fs = ~clk_fs;

  int n_tests = 0;
  int n_fail  = 0;
  int m_max[CH_NUM];
  int m_min[CH_NUM];

  typedef enum int {D_RAND, D_PLAN, D_CONST, D_ALT} dmode_t;
  typedef struct {
    logic [CH_NUM-1:0] mask;
    dmode_t            mode;
    bit                restart;   // re-pulse start mid-scan
    bit                clr;       // irq_clr coincident with done
    int                exp_len;   // expected busy cycles, -1: take from model
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_fs);
    #1;
  endtask

  function automatic int chan_cost(input bit en);
    return en ? (2 + SETTLE + POINTS) : 1;
  endfunction

  task automatic read_all(input string tag);
    for (int c = 0; c < CH_NUM; c++) begin
      rd_ch = CH_W'(c);
      step();
      check($sformatf("%s rd_max[%0d]", tag, c), 32'(rd_max), 32'(m_max[c]));
      check($sformatf("%s rd_min[%0d]", tag, c), 32'(rd_min), 32'(m_min[c]));
      check($sformatf("%s rd_vpp[%0d]", tag, c), 32'(rd_vpp), 32'(m_max[c] - m_min[c]));
    end
  endtask

  // One full scan from an idle DUT. Offset o counts clock edges after the
  // accepting edge. The sample driven after edge o is absorbed at edge o+1.
  task automatic run_scan(input vec_t v, input string tag);
    int base[CH_NUM];
    int dat[256];
    int total, o, k, pos;
    int emax[CH_NUM];
    int emin[CH_NUM];
    total = 0;
    for (int c = 0; c < CH_NUM; c++) begin
      base[c] = total;
      total  += chan_cost(v.mask[c]);
    end
    for (int i = 0; i < 256; i++) dat[i] = int'($urandom_range(0, 4095));
    for (int c = 0; c < CH_NUM; c++) begin
      if (!v.mask[c]) continue;
      for (int s = 0; s < POINTS; s++) begin
        pos = base[c] + 1 + SETTLE + s;
        case (v.mode)
          D_PLAN:  begin
            k = s % 4;
            dat[pos] = 10 * c + ((k == 0) ? 3 : (k == 1) ? 9 : (k == 2) ? 1 : 5);
          end
          D_CONST: dat[pos] = 4095;
          D_ALT:   dat[pos] = (s % 2 == 0) ? 0 : 4095;
          default: ;
        endcase
        if (s == 0 || dat[pos] > emax[c]) emax[c] = dat[pos];
        if (s == 0 || dat[pos] < emin[c]) emin[c] = dat[pos];
      end
    end
    if (v.exp_len < 0) v.exp_len = total;

    start   = 1'b1;
    ch_mask = v.mask;
    data_u  = DATA_W'($urandom);
    step();
    start   = 1'b0;
    ch_mask = CH_NUM'($urandom);
    o = 0;
    while (o < 250) begin
      if (!busy) break;
      for (int c = 0; c < CH_NUM; c++)
        if (v.mask[c] && o == base[c] + 1)
          check($sformatf("%s ch_sel ch%0d", tag, c), 32'(ch_sel), 32'(c));
      start   = v.restart && (o == 5);
      irq_clr = v.clr && (o == total - 1);
      data_u  = DATA_W'(dat[o]);
      step();
      o++;
    end
    start   = 1'b0;
    irq_clr = 1'b0;
    check({tag, " busy_len"}, 32'(o), 32'(v.exp_len));
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " irq"}, 32'(irq), v.clr ? 32'd0 : 32'd1);
    step();
    check({tag, " done_1cyc"}, 32'(done), 32'd0);
    for (int c = 0; c < CH_NUM; c++)
      if (v.mask[c]) begin
        m_max[c] = emax[c];
        m_min[c] = emin[c];
      end
    read_all(tag);
  endtask

  vec_t vecs[8];

  initial begin
    vec_t rv;
    int   o, dones, per;
    // Fixed vectors: mask, data pattern, re-start, irq_clr at done, busy length.
    vecs[0] = '{mask: 4'b1111, mode: D_PLAN,  restart: 1'b0, clr: 1'b0, exp_len: 32};
    vecs[1] = '{mask: 4'b0101, mode: D_RAND,  restart: 1'b0, clr: 1'b0, exp_len: 18};
    vecs[2] = '{mask: 4'b0000, mode: D_RAND,  restart: 1'b0, clr: 1'b0, exp_len: 4};
    vecs[3] = '{mask: 4'b0001, mode: D_CONST, restart: 1'b0, clr: 1'b0, exp_len: 11};
    vecs[4] = '{mask: 4'b0001, mode: D_ALT,   restart: 1'b0, clr: 1'b0, exp_len: 11};
    vecs[5] = '{mask: 4'b1111, mode: D_RAND,  restart: 1'b1, clr: 1'b0, exp_len: 32};
    vecs[6] = '{mask: 4'b1010, mode: D_RAND,  restart: 1'b0, clr: 1'b1, exp_len: 18};
    vecs[7] = '{mask: 4'b0110, mode: D_RAND,  restart: 1'b0, clr: 1'b0, exp_len: 18};
    for (int c = 0; c < CH_NUM; c++) begin
      m_max[c] = 0;
      m_min[c] = 0;
    end

    // Reset state.
    #2;
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst irq", 32'(irq), 32'd0);
    check("rst ch_sel", 32'(ch_sel), 32'd0);
    check("rst rd_max", 32'(rd_max), 32'd0);
    #21 rst_n = 1'b1;
    step();
    read_all("post_rst");

    // Table-driven scans.
    for (int i = 0; i < 8; i++) begin
      run_scan(vecs[i], $sformatf("vec%0d", i));
      if (i == 0) begin
        rd_ch = 2'd2;
        step();
        check("plan ch2 max", 32'(rd_max), 32'd29);
        check("plan ch2 min", 32'(rd_min), 32'd21);
        check("plan ch2 vpp", 32'(rd_vpp), 32'd8);
      end
      if (i == 3) begin
        check("const vpp", 32'(m_max[0] - m_min[0]), 32'd0);
        rd_ch = 2'd0;
        step();
        check("const max", 32'(rd_max), 32'h0FFF);
        check("const vpp_rd", 32'(rd_vpp), 32'd0);
      end
      if (i == 4) begin
        rd_ch = 2'd0;
        step();
        check("alt vpp", 32'(rd_vpp), 32'h0FFF);
      end
    end

    // A standalone irq_clr after done clears the sticky irq.
    check("irq before clr", 32'(irq), 32'd1);
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    check("irq after clr", 32'(irq), 32'd0);
    step();
    check("irq stays clr", 32'(irq), 32'd0);

    // Reset during MEAS of ch1 aborts and clears everything.
    rd_ch   = 2'd2;
    start   = 1'b1;
    ch_mask = 4'b1111;
    step();
    start = 1'b0;
    for (o = 0; o < 12; o++) begin
      data_u = DATA_W'($urandom);
      step();
    end
    check("pre_abort ch_sel", 32'(ch_sel), 32'd1);
    check("pre_abort busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort irq", 32'(irq), 32'd0);
    check("abort ch_sel", 32'(ch_sel), 32'd0);
    check("abort rd_max", 32'(rd_max), 32'd0);
    check("abort rd_vpp", 32'(rd_vpp), 32'd0);
    step();
    rst_n = 1'b1;
    for (int c = 0; c < CH_NUM; c++) begin
      m_max[c] = 0;
      m_min[c] = 0;
    end
    read_all("abort");
    rv = '{mask: 4'b1111, mode: D_RAND, restart: 1'b0, clr: 1'b0, exp_len: 32};
    run_scan(rv, "after_abort");

    // Randomized scans against the model.
    for (int i = 0; i < 10; i++) begin
      rv = '{mask: CH_NUM'($urandom), mode: D_RAND, restart: 1'($urandom),
             clr: 1'($urandom), exp_len: -1};
      run_scan(rv, $sformatf("rnd%0d", i));
    end

`ifdef VPP_SCAN_CONT_EN
    // Continuous mode: three back-to-back scans, cont dropped in the third.
    per     = chan_cost(1'b1) * 2 + chan_cost(1'b0) * 2;
    cont    = 1'b1;
    start   = 1'b1;
    ch_mask = 4'b0011;
    data_u  = 12'h123;
    step();
    start = 1'b0;
    o     = 0;
    dones = 0;
    while (o < 250) begin
      if (!busy) break;
      if (done) dones++;
      if (o == 2 * per + 1) cont = 1'b0;
      step();
      o++;
    end
    check("cont busy_len", 32'(o), 32'(3 * per));
    check("cont done_in_busy", 32'(dones), 32'd2);
    check("cont final done", 32'(done), 32'd1);
    check("cont irq", 32'(irq), 32'd1);
    step();
    m_max[0] = 12'h123; m_min[0] = 12'h123;
    m_max[1] = 12'h123; m_min[1] = 12'h123;
    read_all("cont");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
